// File: rtl/xy_switch_scheduler_pkg.sv
// Shared definitions for the mesh-router scheduler.
//   - Port index constants (fixed 5-port encoding).
//   - FSM state encoding.
package xy_switch_scheduler_pkg;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_EAST  = 2;
  localparam int PORT_SOUTH = 3;
  localparam int PORT_WEST  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/xy_switch_scheduler_route.sv
// xy_route_calc: combinational XY dimension-order route for one input.
//   dst_x_i / dst_y_i : destination coordinates of the waiting flit
//   port_o            : output port index (0=L,1=N,2=E,3=S,4=W)
// X is resolved before Y; all comparisons are unsigned.
module xy_route_calc
  import xy_switch_scheduler_pkg::*;
#(
  parameter int X_W      = 2,
  parameter int Y_W      = 2,
  parameter int ROUTER_X = 0,
  parameter int ROUTER_Y = 0,
  parameter int SEL_W    = 3
) (
  input  logic [X_W-1:0]   dst_x_i,
  input  logic [Y_W-1:0]   dst_y_i,
  output logic [SEL_W-1:0] port_o
);

  localparam logic [X_W-1:0] RX = X_W'(ROUTER_X);
  localparam logic [Y_W-1:0] RY = Y_W'(ROUTER_Y);

  always_comb begin
    port_o = SEL_W'(PORT_LOCAL);
    if (dst_x_i > RX)      port_o = SEL_W'(PORT_EAST);
    else if (dst_x_i < RX) port_o = SEL_W'(PORT_WEST);
    else if (dst_y_i > RY) port_o = SEL_W'(PORT_NORTH);
    else if (dst_y_i < RY) port_o = SEL_W'(PORT_SOUTH);
  end

endmodule

// File: rtl/xy_switch_scheduler.sv
// xy_switch_scheduler: per-router round-robin scheduler with XY routing.
//   clk_i, rst_ni   : clock, async active-low reset
//   vld_input_i     : per-input "flit waiting" flags
//   dst_x_i/dst_y_i : packed per-input destinations, input i at [i*W +: W]
//   full_i          : per-output full flags
//   wr_en_i         : per-output write strobes (transfer done)
//   mux_in_sel_o    : granted input (qualify with grant_vld_o)
//   mux_out_sel_o   : routed output (qualify with grant_vld_o)
//   grant_vld_o     : selects valid
//   grant_o         : one-hot granted input, zero when not valid
// One grant per round with a one-cycle IDLE bubble between grants. A grant
// whose output stays full for STALL_MAX cycles is released (0 disables).
module xy_switch_scheduler
  import xy_switch_scheduler_pkg::*;
#(
  parameter int PORT_N    = 5,
  parameter int X_W       = 2,
  parameter int Y_W       = 2,
  parameter int ROUTER_X  = 0,
  parameter int ROUTER_Y  = 0,
  parameter int STALL_MAX = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [PORT_N-1:0]         vld_input_i,
  input  logic [PORT_N*X_W-1:0]     dst_x_i,
  input  logic [PORT_N*Y_W-1:0]     dst_y_i,
  input  logic [PORT_N-1:0]         full_i,
  input  logic [PORT_N-1:0]         wr_en_i,
  output logic [$clog2(PORT_N)-1:0] mux_in_sel_o,
  output logic [$clog2(PORT_N)-1:0] mux_out_sel_o,
  output logic                      grant_vld_o,
  output logic [PORT_N-1:0]         grant_o
);

  localparam int SEL_W = $clog2(PORT_N);
  // $clog2(1) is 0, so keep at least one bit when release is disabled.
  localparam int CNT_W = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'((STALL_MAX > 0) ? STALL_MAX - 1 : 0);

  // Routes for every input are precomputed; the grant just muxes one.
  logic [PORT_N-1:0][SEL_W-1:0] route;

  for (genvar g = 0; g < PORT_N; g++) begin : g_route
    xy_route_calc #(
      .X_W      (X_W),
      .Y_W      (Y_W),
      .ROUTER_X (ROUTER_X),
      .ROUTER_Y (ROUTER_Y),
      .SEL_W    (SEL_W)
    ) u_route (
      .dst_x_i (dst_x_i[g*X_W +: X_W]),
      .dst_y_i (dst_y_i[g*Y_W +: Y_W]),
      .port_o  (route[g])
    );
  end

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [SEL_W-1:0]  in_sel_q, in_sel_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic              grant_vld_q, grant_vld_d;
  logic [PORT_N-1:0] grant_q, grant_d;

  // Round-robin search: first valid input at or after rr_ptr, wrapping.
  logic             found;
  logic [SEL_W-1:0] pick;
  int               idx;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < PORT_N; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= PORT_N) idx = idx - PORT_N;
      if (!found && vld_input_i[idx]) begin
        found = 1'b1;
        pick  = SEL_W'(idx);
      end
    end
  end

  // Pointer after the current grant; explicit wrap for non-power-of-2 PORT_N.
  logic [SEL_W-1:0] rr_next;
  assign rr_next = (in_sel_q == SEL_W'(PORT_N - 1)) ? '0 : in_sel_q + 1'b1;

  logic wr_hit, out_full, stall_hit;
  assign wr_hit    = wr_en_i[out_sel_q];
  assign out_full  = full_i[out_sel_q];
  assign stall_hit = (STALL_MAX != 0) && out_full && (stall_cnt_q == STALL_LAST);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    stall_cnt_d = stall_cnt_q;
    in_sel_d    = in_sel_q;
    out_sel_d   = out_sel_q;
    grant_vld_d = grant_vld_q;
    grant_d     = grant_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = GRANT;
          in_sel_d      = pick;
          out_sel_d     = route[pick];
          grant_vld_d   = 1'b1;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          stall_cnt_d   = '0;
        end
      end
      GRANT: begin
        // Transfer outranks withdrawal, which outranks the stall release.
        if (wr_hit) begin
          state_d     = IDLE;
          rr_ptr_d    = rr_next;
          grant_vld_d = 1'b0;
          grant_d     = '0;
        end else if (!vld_input_i[in_sel_q]) begin
          state_d     = IDLE;
          grant_vld_d = 1'b0;
          grant_d     = '0;
        end else if (stall_hit) begin
          state_d     = IDLE;
          rr_ptr_d    = rr_next;
          grant_vld_d = 1'b0;
          grant_d     = '0;
        end else if (out_full) begin
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
          stall_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
      in_sel_q    <= '0;
      out_sel_q   <= '0;
      grant_vld_q <= 1'b0;
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
      in_sel_q    <= in_sel_d;
      out_sel_q   <= out_sel_d;
      grant_vld_q <= grant_vld_d;
      grant_q     <= grant_d;
    end
  end

  assign mux_in_sel_o  = in_sel_q;
  assign mux_out_sel_o = out_sel_q;
  assign grant_vld_o   = grant_vld_q;
  assign grant_o       = grant_q;

endmodule

// File: tb/tb_xy_switch_scheduler.sv
// Self-checking bench for xy_switch_scheduler at router (1,1), STALL_MAX=4.
// Directed steps followed by a random phase, all checked against a
// transaction-level reference model of the scheduling rules.
module tb_xy_switch_scheduler;

  localparam int N = 5;
  localparam int RX = 1;
  localparam int RY = 1;
  localparam int SMAX = 4;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b1;
  logic [4:0] vld = '0, full = '0, wr = '0;
  logic [9:0] dx = '0, dy = '0;
  logic [2:0] in_sel, out_sel;
  logic       gv;
  logic [4:0] gnt;

  int errors = 0;
  int checks = 0;

  // Reference model state: is a grant outstanding, which input/output,
  // where the next search starts, and how long the output has been full.
  bit m_busy;
  int m_in, m_out, m_rr, m_cnt;

  always #5 clk = ~clk;

  xy_switch_scheduler #(
    .PORT_N(N), .X_W(2), .Y_W(2), .ROUTER_X(RX), .ROUTER_Y(RY), .STALL_MAX(SMAX)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .vld_input_i(vld), .dst_x_i(dx), .dst_y_i(dy),
    .full_i(full), .wr_en_i(wr), .mux_in_sel_o(in_sel), .mux_out_sel_o(out_sel),
    .grant_vld_o(gv), .grant_o(gnt)
  );

  function automatic int route(int x, int y);
    if (x > RX) return 2;
    if (x < RX) return 4;
    if (y > RY) return 1;
    if (y < RY) return 3;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_in = 0; m_out = 0; m_rr = 0; m_cnt = 0;
  endtask

  task automatic model_clk();
    bit got;
    if (!m_busy) begin
      got = 0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (!got && vld[i]) begin
          got = 1; m_busy = 1; m_in = i; m_cnt = 0;
          m_out = route(int'(dx[i*2 +: 2]), int'(dy[i*2 +: 2]));
        end
      end
    end else if (wr[m_out]) begin
      m_busy = 0; m_rr = (m_in + 1) % N;
    end else if (!vld[m_in]) begin
      m_busy = 0;
    end else if (full[m_out] && m_cnt == SMAX - 1) begin
      m_busy = 0; m_rr = (m_in + 1) % N;
    end else begin
      m_cnt = full[m_out] ? m_cnt + 1 : 0;
    end
  endtask

  task automatic check_model();
    chk("grant_vld", 32'(gv), 32'(m_busy));
    chk("grant", 32'(gnt), m_busy ? (32'd1 << m_in) : 32'd0);
    chk("in_sel", 32'(in_sel), 32'(m_in));
    chk("out_sel", 32'(out_sel), 32'(m_out));
  endtask

  task automatic step();
    @(posedge clk);
    model_clk();
    @(negedge clk);
    check_model();
  endtask

  task automatic set_dst(input int i, input int x, input int y);
    dx[i*2 +: 2] = 2'(x);
    dy[i*2 +: 2] = 2'(y);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    vld = 5'($urandom); full = 5'($urandom); wr = 5'($urandom);
    dx = 10'($urandom); dy = 10'($urandom);
    #1;
    model_reset();
    check_model();
    repeat (2) @(negedge clk);
    check_model();
    vld = '0; full = '0; wr = '0; dx = '0; dy = '0;
    rst_ni = 1'b1;
  endtask

  initial begin
    int seq[$];
    int cnt0, after_in, after_out;
    bit prev;

    // Reset with random inputs, then idle with nothing valid.
    do_reset();
    repeat (3) step();

    // Single route: input 2 to (3,1) goes East; completion moves rr to 3.
    vld = 5'b00100; set_dst(2, 3, 1);
    step();
    chk("single_out_east", 32'(out_sel), 32'd2);
    wr = 5'b00100; vld = '0;
    step();
    wr = '0; vld = 5'b00101;
    step();
    chk("rr_after_single", 32'(in_sel), 32'd0);
    wr = 5'(1 << m_out); vld = '0;
    step();
    wr = '0;

    // XY coverage on input 0, expected ports taken from the routing rules.
    begin
      int tx[6] = '{0, 1, 1, 1, 2, 3};
      int ty[6] = '{2, 2, 0, 1, 0, 3};
      int tp[6] = '{4, 1, 3, 0, 2, 2};
      for (int t = 0; t < 6; t++) begin
        vld = 5'b00001; set_dst(0, tx[t], ty[t]);
        step();
        chk($sformatf("xy_route_%0d_%0d", tx[t], ty[t]), 32'(out_sel), 32'(tp[t]));
        wr = 5'(1 << tp[t]); vld = '0;
        step();
        wr = '0;
      end
    end

    // Fairness: inputs 1 and 3 held, every grant completed the next cycle.
    do_reset();
    vld = 5'b01010; set_dst(1, 0, 0); set_dst(3, 3, 3);
    prev = 0;
    for (int c = 0; c < 20 && seq.size() < 4; c++) begin
      step();
      if (m_busy && !prev) seq.push_back(int'(in_sel));
      prev = m_busy;
      wr = m_busy ? 5'(1 << m_out) : 5'b0;
    end
    chk("fair_count", 32'(seq.size()), 32'd4);
    if (seq.size() == 4) begin
      chk("fair_0", 32'(seq[0]), 32'd1);
      chk("fair_1", 32'(seq[1]), 32'd3);
      chk("fair_2", 32'(seq[2]), 32'd1);
      chk("fair_3", 32'(seq[3]), 32'd3);
    end
    wr = '0; vld = '0;
    step();

    // Stall release: input 0 East with East full; input 4 Local waits.
    do_reset();
    vld = 5'b10001; set_dst(0, 3, 1); set_dst(4, 1, 1); full = 5'b00100;
    cnt0 = 0; after_in = -1; after_out = -1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (gv && in_sel == 3'd0) cnt0++;
      if (gv && in_sel != 3'd0 && after_in < 0) begin
        after_in = int'(in_sel); after_out = int'(out_sel);
      end
    end
    chk("stall_cycles", 32'(cnt0), 32'd4);
    chk("stall_next_in", 32'(after_in), 32'd4);
    chk("stall_next_out", 32'(after_out), 32'd0);

    // Transfer on the same cycle as the stall limit: single rr advance.
    do_reset();
    vld = 5'b00011; set_dst(0, 3, 1); set_dst(1, 3, 1); full = 5'b00100;
    repeat (4) step();
    wr = 5'b00100;
    step();
    chk("both_idle", 32'(gv), 32'd0);
    wr = '0;
    step();
    chk("both_next_in", 32'(in_sel), 32'd1);

    // Withdraw input 1 mid-grant: rr stays at 1.
    full = '0;
    vld = 5'b00001;
    step();
    vld = 5'b00011;
    step();
    chk("withdraw_in", 32'(in_sel), 32'd1);

    // Async reset mid-grant drops outputs before any clock edge.
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_vld", 32'(gv), 32'd0);
    chk("async_grant", 32'(gnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1; vld = '0;
    step();

    // Random phase.
    for (int c = 0; c < 400; c++) begin
      vld  = 5'($urandom);
      dx   = 10'($urandom);
      dy   = 10'($urandom);
      full = 5'($urandom & $urandom);
      wr   = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xy_switch_scheduler.md
Name: xy_switch_scheduler

Overview:
- Per-router scheduler for the 5-port mesh switch with XY routing.
- Picks one buffered input per transfer round-robin and computes its output port by XY dimension-order routing.
- Drives the switch control unit's input/output mux selects and holds the grant until the flit has been written out.
- Releases the grant after a configurable stall limit, so one blocked output cannot starve the other inputs.

Parameters:
- PORT_N, 5: number of ports. Fixed encoding 0=Local, 1=North, 2=East, 3=South, 4=West.
- X_W, 2: width of the destination X coordinate.
- Y_W, 2: width of the destination Y coordinate.
- ROUTER_X, 0: X coordinate of this router.
- ROUTER_Y, 0: Y coordinate of this router.
- STALL_MAX, 8: number of consecutive cycles a granted output may stay full before the grant is released. 0 disables release.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- vld_input_i  input  PORT_N  per-input flag: a flit is latched and waiting.
- dst_x_i  input  PORT_N*X_W  destination X per input; input i occupies bits [i*X_W +: X_W].
- dst_y_i  input  PORT_N*Y_W  destination Y per input; same packing as dst_x_i.
- full_i  input  PORT_N  per-output full flag.
- wr_en_i  input  PORT_N  per-output write strobe from the control unit; marks the transfer as done.
- mux_in_sel_o  output  $clog2(PORT_N)  selected input.
- mux_out_sel_o  output  $clog2(PORT_N)  routed output.
- grant_vld_o  output  1  the selects are valid; the control unit gates writes with this.
- grant_o  output  PORT_N  one-hot of the granted input; all zeros when grant_vld_o=0.

Behaviour:
- All outputs are registered.
- Reset (async, active-low):
  - state=IDLE, rr_ptr=0, stall_cnt=0.
  - All outputs 0.
- XY route for candidate input i, evaluated combinationally:
  - dst_x > ROUTER_X -> East(2).
  - dst_x < ROUTER_X -> West(4).
  - Otherwise, dst_y > ROUTER_Y -> North(1).
  - dst_y < ROUTER_Y -> South(3).
  - Both equal -> Local(0).
  - All comparisons unsigned.
- IDLE state:
  - If vld_input_i == 0, stay in IDLE.
  - Otherwise choose the first set bit searching from rr_ptr upward with wrap modulo PORT_N.
  - On the next edge, register mux_in_sel_o, mux_out_sel_o (XY result) and grant_o, set grant_vld_o=1, clear stall_cnt, and go to GRANT.
  - Latency from vld to grant is 1 cycle.
- GRANT state, priority in this order:
  1. wr_en_i[mux_out_sel_o]=1 (transfer done): rr_ptr <= (in_sel+1) mod PORT_N; go to IDLE; grant_vld_o=0 and grant_o=0 next cycle.
  2. vld_input_i[in_sel]=0 without a write (input withdrawn): go to IDLE; rr_ptr unchanged.
  3. STALL_MAX!=0, full_i[out_sel]=1 and stall_cnt==STALL_MAX-1 (stall limit): release to IDLE; rr_ptr <= (in_sel+1) mod PORT_N.
  4. Otherwise: hold the grant. stall_cnt increments while full_i[out_sel]=1 and resets to 0 when it is 0.
- A transfer and the stall limit on the same cycle: the transfer wins.
- mux_in_sel_o and mux_out_sel_o keep their last values in IDLE. Consumers must qualify them with grant_vld_o.
- One grant per round, with a 1-cycle IDLE bubble between grants. Peak throughput is one flit per 2 cycles.
- Width rules:
  - rr_ptr wraps PORT_N-1 -> 0 explicitly, no power-of-2 assumption.
  - stall_cnt is $clog2(STALL_MAX+1) bits and saturates (never wraps).
- Reset asserted mid-GRANT: outputs and state clear immediately (asynchronously); no transfer is implied.

Decomposition:
- Shared package: port index constants PORT_LOCAL=0, PORT_NORTH=1, PORT_EAST=2, PORT_SOUTH=3, PORT_WEST=4, and the state encoding (IDLE, GRANT).
- One sub-module, xy_route_calc: purely combinational (dst_x, dst_y, ROUTER_X, ROUTER_Y) -> port index. It is instantiated per input so the selected route is a mux of precomputed results.
- Round-robin search and the FSM stay in the top module.

Test Plan:
- Reset: hold rst_ni=0 with random inputs -> grant_vld_o=0, grant_o=0, mux_in_sel_o=0, mux_out_sel_o=0. After release with vld=0, all stay 0.
- Single route (ROUTER=(1,1)): vld=5'b00100, dst_x[2]=3, dst_y[2]=1 -> 1 cycle later grant_o=00100, in_sel=2, out_sel=2 (E). Pulse wr_en_i=00100 -> next cycle grant_vld_o=0 and rr_ptr=3.
- XY coverage at ROUTER=(1,1): dst (0,2)->W(4); (1,2)->N(1); (1,0)->S(3); (1,1)->Local(0); (2,0)->E(2), X resolved before Y.
- Round-robin fairness: vld=01010 held, each grant completed by wr_en_i one cycle after grant -> grant sequence is inputs 1,3,1,3 and never 1,1.
- Stall release with STALL_MAX=4: input 0 routed East, full_i[2]=1 permanently, input 4 valid with Local destination -> grant on input 0 for exactly 4 cycles, then IDLE, then grant on input 4 with out_sel=0.
- Edge cases:
  - Transfer and stall limit on the same cycle -> rr_ptr advances once and no extra grant occurs.
  - Input withdrawn mid-GRANT -> IDLE with rr_ptr unchanged.
  - Async reset mid-GRANT -> grant_vld_o drops without waiting for a clock edge.
